p_reg_patdet_stage: RTL and testbench
=====================================

// Module: p_reg_patdet_stage
// PURPOSE
//  - Output stage directly downstream of the DSP ALU: registers the 48-bit ALU result and its side outputs
//    (P, PCOUT, carry, multiply-sign) and adds pattern detection plus overflow/underflow flags.
//  - Feeds the slice outputs and the P-cascade to the next slice.
//  - Owns all P-path state; the ALU upstream stays purely combinational.
// PARAMETERS
//  - PREG     1                      1 = P path registered (1-cycle latency); 0 = P path combinational
//  - PATTERN  48'h0000_0000_0000     compare pattern for PATTERNDETECT; ~PATTERN is used for PATTERNBDETECT
//  - MASK     48'h3FFF_FFFF_FFFF     per-bit mask, 1 = bit ignored in both comparisons
// PORTS
//  - CLK                 in   1   single clock, rising edge
//  - RST_N               in   1   asynchronous, active-low reset of every register
//  - CEP                 in   1   clock enable for P-path and pattern registers
//  - RSTP                in   1   synchronous reset of P-path and pattern registers, active-high
//  - ALU_P               in   48  ALU result
//  - ALU_CARRYOUT        in   1   ALU carry out
//  - ALU_CARRYCASCOUT    in   1   ALU carry cascade out
//  - ALU_MULTSIGNOUT     in   1   ALU multiply-sign out
//  - P                   out  48  slice result
//  - PCOUT               out  48  cascade copy of P, always equal to P
//  - CARRYOUT            out  1   registered/passed ALU_CARRYOUT
//  - CARRYCASCOUT        out  1   registered/passed ALU_CARRYCASCOUT
//  - MULTSIGNOUT         out  1   registered/passed ALU_MULTSIGNOUT
//  - PATTERNDETECT       out  1   P matches PATTERN on unmasked bits
//  - PATTERNBDETECT      out  1   P matches ~PATTERN on unmasked bits
//  - PATTERNDETECTPAST   out  1   PATTERNDETECT from the previous enabled cycle
//  - PATTERNBDETECTPAST  out  1   PATTERNBDETECT from the previous enabled cycle
//  - OVERFLOW            out  1   PATTERNDETECTPAST & ~PATTERNDETECT & ~PATTERNBDETECT
//  - UNDERFLOW           out  1   PATTERNBDETECTPAST & ~PATTERNDETECT & ~PATTERNBDETECT
// BEHAVIOUR
//  - Reset: RST_N=0 asynchronously clears every register to 0, so every output is 0.
//    Pattern flags reset to 0 even when 0 matches PATTERN.
//  - Compare terms:
//      pd_c  = &(~(ALU_P ^ PATTERN) | MASK)
//      pbd_c = &( (ALU_P ^ PATTERN) | MASK)
//    With MASK all ones, both terms are 1.
//  - PREG=1, per rising CLK edge, priority RSTP > CEP > hold:
//      - RSTP=1: P, carries, MULTSIGNOUT, PATTERN*DETECT and *PAST registers load 0.
//      - CEP=1:  P<=ALU_P; carries/sign <= inputs; PATTERNDETECT<=pd_c; PATTERNBDETECT<=pbd_c;
//                PATTERNDETECTPAST<=PATTERNDETECT (old value); PATTERNBDETECTPAST<=PATTERNBDETECT (old value).
//      - CEP=0: every register holds.
//    Latency from ALU_P to P and the flags is 1 cycle.
//  - PREG=0:
//      - P, PCOUT, carries, sign, PATTERNDETECT and PATTERNBDETECT follow the inputs combinationally.
//      - PATTERNDETECT = pd_c, PATTERNBDETECT = pbd_c.
//      - The *PAST registers still load pd_c/pbd_c under CEP/RSTP, so they show the previous enabled cycle.
//  - OVERFLOW and UNDERFLOW are combinational from the registered flags. They can never both be 1 unless
//    both PAST flags are 1, which only happens with a fully-symmetric MASK.
//  - RSTP and CEP asserted together: reset wins. RST_N released mid-operation: first capture occurs on
//    the first edge with CEP=1.
// CONFIGURATION
//  - Macro AUTORESET_PATDET_EN.
//  - Defined: when PATTERNDETECT=1 (registered value) and CEP=1 at an edge, the P-path and pattern
//    registers load 0 exactly as for RSTP. This gives a self-clearing accumulator/counter terminal count.
//    RSTP still has priority; with PREG=0 only the *PAST registers are affected.
//  - Undefined: no auto-reset logic is present; PATTERNDETECT has no effect on P.
// TESTING
//  - Async reset: RST_N=0 mid-stream with ALU_P=48'h1234 -> all outputs 0 immediately; they stay 0 until
//    the first edge with CEP=1 after release.
//  - Latency/CE: PREG=1, ALU_P=48'h0000_0000_0005, CEP=1 -> P=5 next edge; CEP=0 and ALU_P=9 -> P holds 5.
//  - Pattern: defaults, ALU_P=48'h0000_0000_0005 -> PATTERNDETECT=1;
//    ALU_P=48'hC000_0000_0000 -> PATTERNBDETECT=1; ALU_P=48'h4000_0000_0000 -> both 0.
//  - Overflow: sequence 48'h3FFF_FFFF_FFFF then 48'h4000_0000_0000 with CEP=1 -> second cycle
//    OVERFLOW=1, UNDERFLOW=0. Sequence 48'hC000_0000_0000 then 48'hBFFF_FFFF_FFFF -> UNDERFLOW=1.
//  - Priority: RSTP=1 with CEP=1 and ALU_P=48'hFFFF -> P=0 and all flags 0 next edge.
//  - AUTORESET_PATDET_EN: PATTERN=48'd10, MASK=0, ALU_P counting 8,9,10,11 -> P=10 with PATTERNDETECT=1,
//    then P=0 on the next enabled edge. Without the macro, P=11.

Source files
------------

// File: rtl/p_reg_patdet_stage.sv
// DSP output stage: optional P-path register, pattern/pattern-bar detection and overflow/underflow flags.
// Build option AUTORESET_PATDET_EN: a registered pattern match clears the P-path on the next enabled edge.
module p_reg_patdet_stage #(
    parameter int unsigned PREG    = 1,
    parameter logic [47:0] PATTERN = 48'h0000_0000_0000,
    parameter logic [47:0] MASK    = 48'h3FFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cep,
    input  logic        rstp,
    input  logic [47:0] alu_p,
    input  logic        alu_carryout,
    input  logic        alu_carrycascout,
    input  logic        alu_multsignout,
    output logic [47:0] p,
    output logic [47:0] pcout,
    output logic        carryout,
    output logic        carrycascout,
    output logic        multsignout,
    output logic        patterndetect,
    output logic        patternbdetect,
    output logic        patterndetectpast,
    output logic        patternbdetectpast,
    output logic        overflow,
    output logic        underflow
);

    logic pd_c;
    logic pbd_c;
    logic clr_p;

    assign pd_c  = &(~(alu_p ^ PATTERN) | MASK);
    assign pbd_c = &( (alu_p ^ PATTERN) | MASK);

`ifdef AUTORESET_PATDET_EN
    // Terminal-count self-clear keyed off the currently presented match flag.
    assign clr_p = rstp | (cep & patterndetect);
`else
    assign clr_p = rstp;
`endif

    generate
        if (PREG != 0) begin : g_preg
            logic [47:0] p_q;
            logic        carry_q;
            logic        ccarry_q;
            logic        msign_q;
            logic        pd_q;
            logic        pbd_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_q      <= '0;
                    carry_q  <= 1'b0;
                    ccarry_q <= 1'b0;
                    msign_q  <= 1'b0;
                    pd_q     <= 1'b0;
                    pbd_q    <= 1'b0;
                end else if (clr_p) begin
                    p_q      <= '0;
                    carry_q  <= 1'b0;
                    ccarry_q <= 1'b0;
                    msign_q  <= 1'b0;
                    pd_q     <= 1'b0;
                    pbd_q    <= 1'b0;
                end else if (cep) begin
                    p_q      <= alu_p;
                    carry_q  <= alu_carryout;
                    ccarry_q <= alu_carrycascout;
                    msign_q  <= alu_multsignout;
                    pd_q     <= pd_c;
                    pbd_q    <= pbd_c;
                end
            end

            assign p              = p_q;
            assign carryout       = carry_q;
            assign carrycascout   = ccarry_q;
            assign multsignout    = msign_q;
            assign patterndetect  = pd_q;
            assign patternbdetect = pbd_q;
        end else begin : g_comb
            assign p              = alu_p;
            assign carryout       = alu_carryout;
            assign carrycascout   = alu_carrycascout;
            assign multsignout    = alu_multsignout;
            assign patterndetect  = pd_c;
            assign patternbdetect = pbd_c;
        end
    endgenerate

    // The past flags sample whatever is presented as the current flag: the old register
    // value when registered, or the live compare when combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            patterndetectpast  <= 1'b0;
            patternbdetectpast <= 1'b0;
        end else if (clr_p) begin
            patterndetectpast  <= 1'b0;
            patternbdetectpast <= 1'b0;
        end else if (cep) begin
            patterndetectpast  <= patterndetect;
            patternbdetectpast <= patternbdetect;
        end
    end

    assign pcout     = p;
    assign overflow  = patterndetectpast  & ~patterndetect & ~patternbdetect;
    assign underflow = patternbdetectpast & ~patterndetect & ~patternbdetect;

endmodule

// File: tb/tb_p_reg_patdet_stage.sv
// Bench for p_reg_patdet_stage: combinational, registered and counter-pattern instances on shared stimulus.
module tb_p_reg_patdet_stage;

`ifdef AUTORESET_PATDET_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cep;
    logic        rstp;
    logic [47:0] alu_p;
    logic        alu_carryout;
    logic        alu_carrycascout;
    logic        alu_multsignout;

    logic [47:0] p0, pc0, p1, pc1, p2, pc2;
    logic        co0, cc0, ms0, pd0, pbd0, pdp0, pbdp0, ov0, un0;
    logic        co1, cc1, ms1, pd1, pbd1, pdp1, pbdp1, ov1, un1;
    logic        co2, cc2, ms2, pd2, pbd2, pdp2, pbdp2, ov2, un2;

    int n_err = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    p_reg_patdet_stage #(.PREG(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp), .alu_p(alu_p),
        .alu_carryout(alu_carryout), .alu_carrycascout(alu_carrycascout), .alu_multsignout(alu_multsignout),
        .p(p0), .pcout(pc0), .carryout(co0), .carrycascout(cc0), .multsignout(ms0),
        .patterndetect(pd0), .patternbdetect(pbd0), .patterndetectpast(pdp0), .patternbdetectpast(pbdp0),
        .overflow(ov0), .underflow(un0));

    p_reg_patdet_stage #(.PREG(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp), .alu_p(alu_p),
        .alu_carryout(alu_carryout), .alu_carrycascout(alu_carrycascout), .alu_multsignout(alu_multsignout),
        .p(p1), .pcout(pc1), .carryout(co1), .carrycascout(cc1), .multsignout(ms1),
        .patterndetect(pd1), .patternbdetect(pbd1), .patterndetectpast(pdp1), .patternbdetectpast(pbdp1),
        .overflow(ov1), .underflow(un1));

    p_reg_patdet_stage #(.PREG(1), .PATTERN(48'd10), .MASK(48'd0)) u_cnt (
        .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp), .alu_p(alu_p),
        .alu_carryout(alu_carryout), .alu_carrycascout(alu_carrycascout), .alu_multsignout(alu_multsignout),
        .p(p2), .pcout(pc2), .carryout(co2), .carrycascout(cc2), .multsignout(ms2),
        .patterndetect(pd2), .patternbdetect(pbd2), .patterndetectpast(pdp2), .patternbdetectpast(pbdp2),
        .overflow(ov2), .underflow(un2));

    typedef struct {
        logic [47:0] p;
        logic [2:0]  cs;
        logic [5:0]  fl;
        logic [47:0] p2;
        logic        pd2;
    } exp_t;

    exp_t sb[$];

    // Reference state: m0 = past flags of the combinational instance, m1 = registered instance, m2 = counter instance.
    logic        m0_pdp, m0_pbdp;
    logic [47:0] m1_p;
    logic [2:0]  m1_cs;
    logic        m1_pd, m1_pbd, m1_pdp, m1_pbdp;
    logic [47:0] m2_p;
    logic        m2_pd;

    // Default MASK leaves only bits 47:46 compared against PATTERN=0.
    function automatic logic pd_def(input logic [47:0] a);
        return a[47:46] == 2'b00;
    endfunction

    function automatic logic pbd_def(input logic [47:0] a);
        return a[47:46] == 2'b11;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m0_pdp = 0; m0_pbdp = 0;
        m1_p = '0; m1_cs = '0; m1_pd = 0; m1_pbd = 0; m1_pdp = 0; m1_pbdp = 0;
        m2_p = '0; m2_pd = 0;
    endtask

    task automatic chk_reg_zero(input string tag);
        chk({tag, "_p1"}, p1, 48'd0);
        chk({tag, "_pc1"}, pc1, 48'd0);
        chk({tag, "_cs1"}, 48'({co1, cc1, ms1}), 48'd0);
        chk({tag, "_fl1"}, 48'({pd1, pbd1, pdp1, pbdp1, ov1, un1}), 48'd0);
        chk({tag, "_p2"}, p2, 48'd0);
        chk({tag, "_past0"}, 48'({pdp0, pbdp0, ov0, un0}), 48'd0);
    endtask

    task automatic step(input string tag, input logic [47:0] a, input logic [2:0] c,
                        input logic ce, input logic rs);
        exp_t e;
        logic cpd, cpbd, clr;
        @(negedge clk);
        alu_p = a;
        {alu_carryout, alu_carrycascout, alu_multsignout} = c;
        cep = ce;
        rstp = rs;
        #1;
        cpd  = pd_def(a);
        cpbd = pbd_def(a);
        chk({tag, "_comb_p"}, p0, a);
        chk({tag, "_comb_pcout"}, pc0, a);
        chk({tag, "_comb_cs"}, 48'({co0, cc0, ms0}), 48'(c));
        chk({tag, "_comb_fl"}, 48'({pd0, pbd0, pdp0, pbdp0, ov0, un0}),
            48'({cpd, cpbd, m0_pdp, m0_pbdp, m0_pdp & ~cpd & ~cpbd, m0_pbdp & ~cpd & ~cpbd}));

        clr = rs | (AUTO & ce & cpd);
        if (clr) begin
            m0_pdp = 0; m0_pbdp = 0;
        end else if (ce) begin
            m0_pdp = cpd; m0_pbdp = cpbd;
        end

        clr = rs | (AUTO & ce & m1_pd);
        if (clr) begin
            m1_p = '0; m1_cs = '0; m1_pd = 0; m1_pbd = 0; m1_pdp = 0; m1_pbdp = 0;
        end else if (ce) begin
            m1_pdp = m1_pd; m1_pbdp = m1_pbd;
            m1_p = a; m1_cs = c; m1_pd = pd_def(a); m1_pbd = pbd_def(a);
        end

        clr = rs | (AUTO & ce & m2_pd);
        if (clr) begin
            m2_p = '0; m2_pd = 0;
        end else if (ce) begin
            m2_p = a; m2_pd = (a == 48'd10);
        end

        e.p  = m1_p;
        e.cs = m1_cs;
        e.fl = {m1_pd, m1_pbd, m1_pdp, m1_pbdp, m1_pdp & ~m1_pd & ~m1_pbd, m1_pbdp & ~m1_pd & ~m1_pbd};
        e.p2 = m2_p;
        e.pd2 = m2_pd;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "_p"}, p1, e.p);
        chk({tag, "_pcout"}, pc1, e.p);
        chk({tag, "_cs"}, 48'({co1, cc1, ms1}), 48'(e.cs));
        chk({tag, "_fl"}, 48'({pd1, pbd1, pdp1, pbdp1, ov1, un1}), 48'(e.fl));
        chk({tag, "_cnt_p"}, p2, e.p2);
        chk({tag, "_cnt_pd"}, 48'(pd2), 48'(e.pd2));
    endtask

    initial begin
        rst_n = 1'b0;
        cep = 1'b0;
        rstp = 1'b0;
        alu_p = '0;
        {alu_carryout, alu_carrycascout, alu_multsignout} = 3'b111;
        model_reset();
        #12;
        // alu_p=0 matches the default pattern, yet the flags must still read 0 under reset.
        chk_reg_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("lat5",   48'h0000_0000_0005, 3'b000, 1'b1, 1'b0);
        chk("lat5_direct", p1, 48'd5);
        step("hold9",  48'h0000_0000_0009, 3'b111, 1'b0, 1'b0);
        chk("hold9_direct", p1, 48'd5);
        step("patb",   48'hC000_0000_0000, 3'b000, 1'b1, 1'b0);
        step("none",   48'h4000_0000_0000, 3'b000, 1'b1, 1'b0);
        step("ov_a",   48'h3FFF_FFFF_FFFF, 3'b000, 1'b1, 1'b0);
        step("ov_b",   48'h4000_0000_0000, 3'b000, 1'b1, 1'b0);
        step("un_a",   48'hC000_0000_0000, 3'b000, 1'b1, 1'b0);
        step("un_b",   48'hBFFF_FFFF_FFFF, 3'b000, 1'b1, 1'b0);
        step("carry",  48'h0000_0000_1234, 3'b101, 1'b1, 1'b0);
        step("carry2", 48'h0000_0000_1234, 3'b010, 1'b1, 1'b0);
        step("prio",   48'h0000_0000_FFFF, 3'b111, 1'b1, 1'b1);
        chk_reg_zero("prio_direct");

        step("cnt8",   48'd8,  3'b000, 1'b1, 1'b0);
        step("cnt9",   48'd9,  3'b000, 1'b1, 1'b0);
        step("cnt10",  48'd10, 3'b000, 1'b1, 1'b0);
        chk("cnt10_direct", 48'({pd2}), 48'd1);
        step("cnt11",  48'd11, 3'b000, 1'b1, 1'b0);
        chk("cnt11_direct", p2, AUTO ? 48'd0 : 48'd11);

        // Asynchronous reset dropped between clock edges while the stream is live.
        step("pre_ar", 48'h0000_0000_1234, 3'b111, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reg_zero("async");
        model_reset();
        cep = 1'b0;
        #1;
        rst_n = 1'b1;
        step("post_ar_hold", 48'h0000_0000_1234, 3'b111, 1'b0, 1'b0);
        chk("post_ar_hold_direct", p1, 48'd0);
        step("post_ar_cap",  48'h0000_0000_1234, 3'b111, 1'b1, 1'b0);
        chk("post_ar_cap_direct", p1, 48'h1234);

        for (int i = 0; i < 40; i++) begin
            logic [47:0] a;
            a = {16'($urandom), 32'($urandom)};
            a[47:46] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = 48'd10;
            step("rand", a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
